// File: rtl/tank_ctrl_p.sv
// Player-tank controller: button sync, grid motion, shot cooldown, bullet hits, lives FSM.
// Optional respawn shield is enabled by defining TANK_CTRL_SHIELD_EN.
module tank_ctrl_p #(
   parameter int XW         = 5,
   parameter int YW         = 5,
   parameter int X_MIN      = 1,
   parameter int X_MAX      = 15,
   parameter int Y_MIN      = 1,
   parameter int Y_MAX      = 19,
   parameter int SPAWN_X    = 8,
   parameter int SPAWN_Y    = 1,
   parameter int NUM_BUL    = 4,
   parameter int LIVES      = 3,
   parameter int LW         = 2,
   parameter int EXPL_TICKS = 4,
   parameter int SHOT_CD    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tank_en,
   input  logic                  move_tick,
   input  logic                  bt_w,
   input  logic                  bt_s,
   input  logic                  bt_a,
   input  logic                  bt_d,
   input  logic                  bt_st,
   input  logic [NUM_BUL-1:0]    bul_vld,
   input  logic [NUM_BUL*XW-1:0] bul_x,
   input  logic [NUM_BUL*YW-1:0] bul_y,
   output logic [XW-1:0]         x_pos,
   output logic [YW-1:0]         y_pos,
   output logic [1:0]            tank_dir,
   output logic                  tank_alive,
   output logic                  bul_sht,
   output logic [LW-1:0]         lives,
   output logic                  game_over
`ifdef TANK_CTRL_SHIELD_EN
   ,
   output logic                  shield_on
`endif
);

   localparam int CDW = (SHOT_CD > 0) ? $clog2(SHOT_CD + 1) : 1;
   localparam int ETW = $clog2(EXPL_TICKS + 1);

   typedef enum logic [1:0] {
      ST_ALIVE   = 2'd0,
      ST_EXPLODE = 2'd1,
      ST_RESPAWN = 2'd2,
      ST_DEAD    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [4:0]      sync1_q, sync1_d, sync2_q, sync2_d;
   logic            st_prev_q, st_prev_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [1:0]      dir_q, dir_d;
   logic [LW-1:0]   lives_q, lives_d;
   logic [CDW-1:0]  cd_q, cd_d;
   logic [ETW-1:0]  et_q, et_d;
   logic            hit_q, hit_d;
   logic            sht_q, sht_d;
   logic [3:0]      shield_q, shield_d;
   logic            hit_any;
   logic            shield_act;
   logic            st_rise;

   always_comb begin
      hit_any = 1'b0;
      for (int i = 0; i < NUM_BUL; i++) begin
         if (bul_vld[i] && (bul_x[i*XW +: XW] == x_q) && (bul_y[i*YW +: YW] == y_q))
            hit_any = 1'b1;
      end
   end

   always_comb begin
      // Sync chain and edge detector run even when frozen so edges seen during freeze are consumed.
      sync1_d    = {bt_st, bt_d, bt_a, bt_s, bt_w};
      sync2_d    = sync1_q;
      st_prev_d  = sync2_q[4];
      st_rise    = sync2_q[4] & ~st_prev_q;
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      dir_d      = dir_q;
      lives_d    = lives_q;
      cd_d       = cd_q;
      et_d       = et_q;
      hit_d      = hit_q;
      sht_d      = 1'b0;
      shield_d   = shield_q;
`ifdef TANK_CTRL_SHIELD_EN
      shield_act = (shield_q != 4'd0);
`else
      shield_act = 1'b0;
`endif

      if (tank_en) begin
`ifdef TANK_CTRL_SHIELD_EN
         if (move_tick && shield_q != 4'd0)
            shield_d = shield_q - 4'd1;
`endif
         case (state_q)
            ST_ALIVE: begin
               if (move_tick && cd_q != '0)
                  cd_d = cd_q - CDW'(1);
               if (hit_q) begin
                  // A pending hit pre-empts any move or shot in this cycle.
                  if (lives_q != '0)
                     lives_d = lives_q - LW'(1);
                  state_d = ST_EXPLODE;
                  et_d    = '0;
                  hit_d   = 1'b0;
               end else begin
                  if (move_tick) begin
                     if (sync2_q[0]) begin
                        dir_d = 2'b00;
                        if (int'(y_q) < Y_MAX) y_d = y_q + YW'(1);
                     end else if (sync2_q[1]) begin
                        dir_d = 2'b01;
                        if (int'(y_q) > Y_MIN) y_d = y_q - YW'(1);
                     end else if (sync2_q[2]) begin
                        dir_d = 2'b10;
                        if (int'(x_q) > X_MIN) x_d = x_q - XW'(1);
                     end else if (sync2_q[3]) begin
                        dir_d = 2'b11;
                        if (int'(x_q) < X_MAX) x_d = x_q + XW'(1);
                     end
                  end
                  if (st_rise && cd_q == '0) begin
                     sht_d = 1'b1;
                     cd_d  = CDW'(SHOT_CD);
                  end
                  hit_d = hit_any & ~shield_act;
               end
            end
            ST_EXPLODE: begin
               if (move_tick) begin
                  if (int'(et_q) == EXPL_TICKS - 1) begin
                     et_d    = '0;
                     state_d = (lives_q == '0) ? ST_DEAD : ST_RESPAWN;
                  end else begin
                     et_d = et_q + ETW'(1);
                  end
               end
            end
            ST_RESPAWN: begin
               x_d     = XW'(SPAWN_X);
               y_d     = YW'(SPAWN_Y);
               dir_d   = 2'b00;
               cd_d    = '0;
               hit_d   = 1'b0;
               state_d = ST_ALIVE;
`ifdef TANK_CTRL_SHIELD_EN
               shield_d = 4'd8;
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ALIVE;
         sync1_q   <= '0;
         sync2_q   <= '0;
         st_prev_q <= 1'b0;
         x_q       <= XW'(SPAWN_X);
         y_q       <= YW'(SPAWN_Y);
         dir_q     <= 2'b00;
         lives_q   <= LW'(LIVES);
         cd_q      <= '0;
         et_q      <= '0;
         hit_q     <= 1'b0;
         sht_q     <= 1'b0;
         shield_q  <= 4'd0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         st_prev_q <= st_prev_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dir_q     <= dir_d;
         lives_q   <= lives_d;
         cd_q      <= cd_d;
         et_q      <= et_d;
         hit_q     <= hit_d;
         sht_q     <= sht_d;
         shield_q  <= shield_d;
      end
   end

   assign x_pos      = x_q;
   assign y_pos      = y_q;
   assign tank_dir   = dir_q;
   assign tank_alive = (state_q == ST_ALIVE);
   assign game_over  = (state_q == ST_DEAD);
   assign lives      = lives_q;
   assign bul_sht    = sht_q & tank_en;
`ifdef TANK_CTRL_SHIELD_EN
   assign shield_on  = (shield_q != 4'd0);
`endif

endmodule

// File: tb/tb_tank_ctrl_p.sv
// Directed bench for tank_ctrl_p: movement table plus shot, hit, death, reset and freeze sequences.
module tb_tank_ctrl_p;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tank_en;
   logic        move_tick;
   logic        bt_w, bt_s, bt_a, bt_d, bt_st;
   logic [3:0]  bul_vld;
   logic [19:0] bul_x;
   logic [19:0] bul_y;
   logic [4:0]  x_pos;
   logic [4:0]  y_pos;
   logic [1:0]  tank_dir;
   logic        tank_alive;
   logic        bul_sht;
   logic [1:0]  lives;
   logic        game_over;
`ifdef TANK_CTRL_SHIELD_EN
   logic        shield_on;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tank_ctrl_p dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tank_en    (tank_en),
      .move_tick  (move_tick),
      .bt_w       (bt_w),
      .bt_s       (bt_s),
      .bt_a       (bt_a),
      .bt_d       (bt_d),
      .bt_st      (bt_st),
      .bul_vld    (bul_vld),
      .bul_x      (bul_x),
      .bul_y      (bul_y),
      .x_pos      (x_pos),
      .y_pos      (y_pos),
      .tank_dir   (tank_dir),
      .tank_alive (tank_alive),
      .bul_sht    (bul_sht),
      .lives      (lives),
      .game_over  (game_over)
`ifdef TANK_CTRL_SHIELD_EN
      ,
      .shield_on  (shield_on)
`endif
   );

   typedef struct {
      logic w, s, a, d;
      int   n;
      int   ex, ey, ed;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic clks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic tick();
      @(negedge clk);
      move_tick = 1'b1;
      @(negedge clk);
      move_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_btn(input logic w, input logic s, input logic a, input logic d);
      @(negedge clk);
      bt_w = w; bt_s = s; bt_a = a; bt_d = d;
      clks(3);
   endtask

   // Single rising edge on bt_st, then count pulses over the following window.
   task automatic shot_try(input string nm, input int exp_cnt);
      int cnt;
      cnt = 0;
      @(negedge clk);
      bt_st = 1'b1;
      @(negedge clk);
      bt_st = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (bul_sht) cnt++;
         @(negedge clk);
      end
      chk(nm, cnt, exp_cnt);
   endtask

   task automatic apply_bullets();
      @(negedge clk);
      bul_x = '0;
      bul_y = '0;
      bul_x[1*5 +: 5] = 5'd8;
      bul_y[1*5 +: 5] = 5'd1;
      bul_x[3*5 +: 5] = 5'd8;
      bul_y[3*5 +: 5] = 5'd1;
      bul_vld = 4'b0010;
   endtask

   task automatic clear_bullets();
      bul_vld = 4'b0000;
   endtask

   task automatic do_hit(input int exp_lives);
      apply_bullets();
      clks(2);
      clear_bullets();
      chk("hit_lives", lives, exp_lives);
      chk("hit_alive", tank_alive, 0);
      ticks(4);
      clks(1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clks(2);
      rst_n = 1'b1;
      clks(1);
   endtask

   task automatic wait_shield();
`ifdef TANK_CTRL_SHIELD_EN
      ticks(8);
`endif
   endtask

   initial begin
      int first, cnt;
      tbl[0]  = '{w:1, s:0, a:0, d:0, n:5,  ex:8, ey:6,  ed:0};
      tbl[1]  = '{w:1, s:0, a:0, d:0, n:20, ex:8, ey:19, ed:0};
      tbl[2]  = '{w:0, s:1, a:0, d:0, n:3,  ex:8, ey:16, ed:1};
      tbl[3]  = '{w:1, s:0, a:1, d:0, n:1,  ex:8, ey:17, ed:0};
      tbl[4]  = '{w:0, s:0, a:1, d:0, n:7,  ex:1, ey:17, ed:2};
      tbl[5]  = '{w:0, s:0, a:1, d:0, n:1,  ex:1, ey:17, ed:2};
      tbl[6]  = '{w:0, s:0, a:0, d:1, n:2,  ex:3, ey:17, ed:3};
      tbl[7]  = '{w:0, s:0, a:1, d:1, n:1,  ex:2, ey:17, ed:2};
      tbl[8]  = '{w:0, s:1, a:0, d:1, n:1,  ex:2, ey:16, ed:1};
      tbl[9]  = '{w:0, s:1, a:0, d:0, n:20, ex:2, ey:1,  ed:1};
      tbl[10] = '{w:0, s:0, a:0, d:1, n:6,  ex:8, ey:1,  ed:3};

      rst_n = 1'b0; tank_en = 1'b1; move_tick = 1'b0;
      bt_w = 0; bt_s = 0; bt_a = 0; bt_d = 0; bt_st = 0;
      bul_vld = '0; bul_x = '0; bul_y = '0;
      clks(2);
      chk("rst_x", x_pos, 8);
      chk("rst_y", y_pos, 1);
      chk("rst_dir", tank_dir, 0);
      chk("rst_alive", tank_alive, 1);
      chk("rst_sht", bul_sht, 0);
      chk("rst_lives", lives, 3);
      chk("rst_over", game_over, 0);
      rst_n = 1'b1;
      clks(1);

      for (int r = 0; r < 11; r++) begin
         set_btn(tbl[r].w, tbl[r].s, tbl[r].a, tbl[r].d);
         ticks(tbl[r].n);
         chk($sformatf("mv%0d_x", r), x_pos, tbl[r].ex);
         chk($sformatf("mv%0d_y", r), y_pos, tbl[r].ey);
         chk($sformatf("mv%0d_dir", r), tank_dir, tbl[r].ed);
         set_btn(0, 0, 0, 0);
      end

      // Three rises two clks apart: one pulse, seen after the third edge following the first rise.
      first = -1; cnt = 0;
      @(negedge clk);
      bt_st = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (bul_sht) begin
            cnt++;
            if (first < 0) first = i;
         end
         bt_st = (i == 2 || i == 4) ? 1'b1 : 1'b0;
      end
      chk("shot_cnt", cnt, 1);
      chk("shot_lat", first, 3);
      tick();
      shot_try("shot_cd1", 0);
      tick();
      shot_try("shot_cd0", 1);
      ticks(2);

      do_hit(2);
      chk("resp_state", tank_alive, 1);
      chk("resp_x", x_pos, 8);
      chk("resp_y", y_pos, 1);
      chk("resp_dir", tank_dir, 0);
      chk("resp_lives", lives, 2);

`ifdef TANK_CTRL_SHIELD_EN
      chk("shield_on", shield_on, 1);
      apply_bullets();
      clks(3);
      clear_bullets();
      chk("shield_lives", lives, 2);
      chk("shield_alive", tank_alive, 1);
      ticks(8);
      chk("shield_off", shield_on, 0);
`endif

      wait_shield();
      do_hit(1);
      wait_shield();
      do_hit(0);
      chk("dead_over", game_over, 1);
      chk("dead_alive", tank_alive, 0);
      chk("dead_lives", lives, 0);
      set_btn(1, 0, 0, 0);
      ticks(3);
      chk("dead_y", y_pos, 1);
      chk("dead_over2", game_over, 1);
      set_btn(0, 0, 0, 0);

      do_reset();
      apply_bullets();
      clks(2);
      clear_bullets();
      ticks(2);
      chk("mid_expl_alive", tank_alive, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_alive", tank_alive, 1);
      chk("async_lives", lives, 3);
      chk("async_over", game_over, 0);
      chk("async_x", x_pos, 8);
      clks(1);
      rst_n = 1'b1;
      clks(1);

      // Freeze: moves, shot edges and timers all held while disabled.
      cnt = 0;
      @(negedge clk);
      tank_en = 1'b0;
      bt_d = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bt_st = 1'b1;
         if (bul_sht) cnt++;
         @(negedge clk);
         bt_st = 1'b0;
         move_tick = 1'b1;
         if (bul_sht) cnt++;
         @(negedge clk);
         move_tick = 1'b0;
         if (bul_sht) cnt++;
      end
      bt_d = 1'b0;
      clks(3);
      chk("frz_x", x_pos, 8);
      chk("frz_sht", cnt, 0);
      tank_en = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bul_sht) cnt++;
      end
      chk("frz_discard", cnt, 0);
      chk("frz_x2", x_pos, 8);
      shot_try("frz_cd", 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got 0 want 1");
      $fatal(1, "timeout");
   end

endmodule
